// File: rtl/mem_stall_ctrl_pkg.sv
// Shared constants for the memory-wait sequencer: opcode classes and FSM encoding.
package mem_stall_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    OTHER = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] op);
    case (op)
      OP_LOAD:  return LOAD;
      OP_STORE: return STORE;
      default:  return OTHER;
    endcase
  endfunction

endpackage

// File: rtl/lat_down_counter.sv
// Loadable down-counter with hold, zero flag and optional saturation at all-ones.
module lat_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         sat,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // With sat set, 0 wraps to all-ones once and then sticks there.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !(sat && (&cnt)))
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_stall_ctrl.sv
// Memory-wait sequencer: holds PC and write-back while a load/store completes.
// Optional MEM_ACK_EN: WAIT exits on mem_ack instead of on the latency count.
module mem_stall_ctrl
  import mem_stall_pkg::*;
#(
  parameter int LOAD_LAT  = 1,
  parameter int STORE_LAT = 0,
  parameter int CNT_W     = 4,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic              stall_in,
  input  logic              mem_ack,
  output logic              pc_enable,
  output logic              reg_write_load,
  output logic              mem_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  if (LOAD_LAT < 0 || LOAD_LAT > (1 << CNT_W) - 1) begin : g_bad_load_lat
    $error("mem_stall_ctrl: LOAD_LAT does not fit in CNT_W bits");
  end
  if (STORE_LAT < 0 || STORE_LAT > (1 << CNT_W) - 1) begin : g_bad_store_lat
    $error("mem_stall_ctrl: STORE_LAT does not fit in CNT_W bits");
  end

  localparam bit LD_STALL = (LOAD_LAT > 0);
  localparam bit ST_STALL = (STORE_LAT > 0);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LD_STALL ? LOAD_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] ST_INIT = CNT_W'(ST_STALL ? STORE_LAT - 1 : 0);

  logic [1:0]       state, state_nxt;
  op_class_e        cls;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_sat;
  logic [CNT_W-1:0] cnt_init, cnt;

`ifdef MEM_ACK_EN
  assign cnt_sat = 1'b1;
  logic unused_sig;
  assign unused_sig = ^{cnt, cnt_zero};
`else
  assign cnt_sat = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{cnt, mem_ack};
`endif

  lat_down_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_init),
    .dec      (cnt_dec),
    .sat      (cnt_sat),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Reset and stall_in both force the gates low and freeze everything.
  always_comb begin
    cls            = classify(opcode);
    state_nxt      = state;
    pc_enable      = 1'b0;
    reg_write_load = 1'b0;
    cnt_load       = 1'b0;
    cnt_init       = LD_INIT;
    cnt_dec        = 1'b0;
    if (!rst && !stall_in) begin
      case (state)
        IDLE: begin
          if (cls == LOAD && LD_STALL) begin
            cnt_load  = 1'b1;
            cnt_init  = LD_INIT;
            state_nxt = WAIT;
          end else if (cls == STORE && ST_STALL) begin
            cnt_load  = 1'b1;
            cnt_init  = ST_INIT;
            state_nxt = WAIT;
          end else begin
            pc_enable      = 1'b1;
            reg_write_load = 1'b1;
          end
        end
        WAIT: begin
`ifdef MEM_ACK_EN
          if (mem_ack) state_nxt = DONE;
          else         cnt_dec   = 1'b1;
`else
          if (cnt_zero) state_nxt = DONE;
          else          cnt_dec   = 1'b1;
`endif
        end
        DONE: begin
          pc_enable      = 1'b1;
          reg_write_load = 1'b1;
          state_nxt      = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mem_busy = !rst && (state == WAIT || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_enable) stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench: three differently parameterised sequencers share stimulus,
// a cycle-budget model predicts each output, a monitor compares on negedge.
module tb_mem_stall_ctrl;
  import mem_stall_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, stall_in = 1'b0, mem_ack = 1'b0;
  logic [6:0] opcode = 7'b0010011;
  logic [N-1:0] pce, rwl, busy;
  logic [3:0]  sc0;
  logic [31:0] sc1;
  logic [7:0]  sc2;
  logic [N-1:0][31:0] sca;

  assign sca[0] = {28'b0, sc0};
  assign sca[1] = sc1;
  assign sca[2] = {24'b0, sc2};

  always #5 clk = ~clk;

  mem_stall_ctrl #(.LOAD_LAT(1), .STORE_LAT(0), .CNT_W(4), .PERF_W(4)) u0 (
    .clk(clk), .rst(rst), .opcode(opcode), .stall_in(stall_in), .mem_ack(mem_ack),
    .pc_enable(pce[0]), .reg_write_load(rwl[0]), .mem_busy(busy[0]), .stall_cnt(sc0));
  mem_stall_ctrl #(.LOAD_LAT(3), .STORE_LAT(0), .CNT_W(4), .PERF_W(32)) u1 (
    .clk(clk), .rst(rst), .opcode(opcode), .stall_in(stall_in), .mem_ack(mem_ack),
    .pc_enable(pce[1]), .reg_write_load(rwl[1]), .mem_busy(busy[1]), .stall_cnt(sc1));
  mem_stall_ctrl #(.LOAD_LAT(2), .STORE_LAT(5), .CNT_W(4), .PERF_W(8)) u2 (
    .clk(clk), .rst(rst), .opcode(opcode), .stall_in(stall_in), .mem_ack(mem_ack),
    .pc_enable(pce[2]), .reg_write_load(rwl[2]), .mem_busy(busy[2]), .stall_cnt(sc2));

  function automatic int ld_lat(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction
  function automatic int st_lat(int k);
    return (k == 2) ? 5 : 0;
  endfunction
  function automatic int perf_w(int k);
    return (k == 0) ? 4 : (k == 1) ? 32 : 8;
  endfunction

  typedef struct {
    logic [N-1:0]       pce, rwl, busy;
    logic [N-1:0][31:0] sc;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  // Model: an instruction owns a budget of held cycles; after it drains, one release cycle.
  int     left    [N];
  bit     waiting [N];
  bit     pend    [N];
  longint scnt    [N];

  initial for (int k = 0; k < N; k++) begin
    left[k] = 0; waiting[k] = 0; pend[k] = 0; scnt[k] = 0;
  end

  task automatic step(input logic r, input logic s, input logic [6:0] op, input logic a);
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    rst = r; stall_in = s; opcode = op; mem_ack = a;
    for (int k = 0; k < N; k++) begin
      lat = (op == OP_LOAD) ? ld_lat(k) : (op == OP_STORE) ? st_lat(k) : 0;
      e.sc[k]   = 32'(scnt[k]);
      e.pce[k]  = 1'b0;
      e.rwl[k]  = 1'b0;
      e.busy[k] = 1'b0;
      if (r) begin
        waiting[k] = 0; pend[k] = 0; left[k] = 0; scnt[k] = 0;
      end else begin
        e.busy[k] = waiting[k] || pend[k];
        if (s) begin
        end else if (waiting[k]) begin
`ifdef MEM_ACK_EN
          if (a) begin waiting[k] = 0; pend[k] = 1; end
`else
          left[k] = left[k] - 1;
          if (left[k] == 0) begin waiting[k] = 0; pend[k] = 1; end
`endif
        end else if (pend[k]) begin
          e.pce[k] = 1'b1; e.rwl[k] = 1'b1; pend[k] = 0;
        end else if (lat == 0) begin
          e.pce[k] = 1'b1; e.rwl[k] = 1'b1;
        end else begin
          waiting[k] = 1; left[k] = lat;
        end
        if (!e.pce[k]) scnt[k] = (scnt[k] + 1) & ((64'd1 << perf_w(k)) - 1);
      end
    end
    q.push_back(e);
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < N; k++) begin
          check("pc_enable",      k, 32'(pce[k]),  32'(e.pce[k]));
          check("reg_write_load", k, 32'(rwl[k]),  32'(e.rwl[k]));
          check("mem_busy",       k, 32'(busy[k]), 32'(e.busy[k]));
          check("stall_cnt",      k, sca[k],       e.sc[k]);
        end
      end
    end
  end

  initial begin : driver
    logic [6:0] other;
    int x;
    other = 7'b0010011;
    step(1, 0, other, 0);
    step(1, 0, other, 0);
    for (int i = 0; i < 3; i++) step(0, 0, OP_LOAD, 0);
    for (int i = 0; i < 2; i++) step(0, 0, other, 0);
    step(0, 0, OP_STORE, 0);
    for (int i = 0; i < 6; i++) step(0, 0, OP_LOAD, 0);
    step(0, 0, OP_LOAD, 0);
    step(0, 0, OP_LOAD, 0);
    for (int i = 0; i < 3; i++) step(0, 1, OP_LOAD, 0);
    for (int i = 0; i < 4; i++) step(0, 0, OP_LOAD, 0);
    step(0, 0, OP_LOAD, 0);
    step(0, 0, OP_LOAD, 0);
    step(1, 0, OP_LOAD, 0);
    step(0, 0, other, 0);
    for (int i = 0; i < 40; i++) step(0, 0, OP_LOAD, 0);
    step(0, 0, other, 0);
    step(0, 0, other, 0);
    step(0, 0, OP_LOAD, 0);
    for (int i = 0; i < 6; i++) step(0, 0, other, 0);
    step(0, 0, other, 1);
    for (int i = 0; i < 8; i++) step(0, 0, other, 0);
    for (int i = 0; i < 1500; i++) begin
      x = $urandom_range(9);
      step($urandom_range(99) < 2, $urandom_range(99) < 12,
           (x < 4) ? OP_LOAD : (x < 7) ? OP_STORE : 7'($urandom),
           $urandom_range(99) < 25);
    end
    @(negedge clk); #1;
    check("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
